// File: rtl/lenet_frame_sequencer.sv
// Batch sequencer for a LeNet-style accelerator: resets and enables the core per frame,
// captures the final-layer scores on a ready3 rising edge and reports the argmax class.
module lenet_frame_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int RST_HOLD    = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [7:0]                     num_frames,
  input  logic                           ready3,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  output logic                           acc_en,
  output logic                           acc_rst_n,
  output logic [3:0]                     class_id,
  output logic signed [SCORE_W-1:0]      max_score,
  output logic                           class_valid,
  output logic                           timeout_err,
  output logic [7:0]                     frame_cnt,
  output logic                           busy,
  output logic                           done
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_RST, S_RUN, S_SCAN, S_REPORT, S_EN_OFF, S_DONE
  } state_t;

  state_t state, next_state;

  logic [3:0]       hold_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             r3_prev;
  logic             tmo_flag;
  logic [3:0]       idx;
  logic [7:0]       num_q;

  logic [NUM_CLASSES*SCORE_W-1:0] scores_p0;
  logic signed [SCORE_W-1:0]      best_p1;
  logic [3:0]                     best_idx_p1;

  logic acc_en_d, acc_rst_n_d, busy_d, done_d;
  logic start_ok, r3_rise, hold_last, tmo_hit, scan_last;

  function automatic logic signed [SCORE_W-1:0] score_at(
    input logic [NUM_CLASSES*SCORE_W-1:0] vec,
    input logic [3:0]                     sel
  );
    return vec[int'(sel)*SCORE_W +: SCORE_W];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start_ok  = start && (num_frames != 8'd0);
  assign r3_rise   = (state == S_RUN) && ready3 && !r3_prev;
  assign hold_last = (hold_cnt == 4'(RST_HOLD - 1));
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign scan_last = (idx == 4'(NUM_CLASSES - 1));

  // Outputs are registered from next_state so they line up with the state exactly
  // while still resetting to all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc_en    <= 1'b0;
      acc_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      acc_en    <= acc_en_d;
      acc_rst_n <= acc_rst_n_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (start) next_state = (num_frames != 8'd0) ? S_PRE_RST : S_DONE;
      S_PRE_RST: if (hold_last) next_state = S_RUN;
      S_RUN: begin
        if (r3_rise)      next_state = S_SCAN;
        else if (tmo_hit) next_state = S_REPORT;
      end
      S_SCAN:    if (scan_last) next_state = S_REPORT;
      S_REPORT:  next_state = S_EN_OFF;
      S_EN_OFF:  next_state = (frame_cnt < num_q) ? S_PRE_RST : S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    acc_en_d    = 1'b0;
    acc_rst_n_d = 1'b1;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    case (next_state)
      S_IDLE:                  busy_d      = 1'b0;
      S_PRE_RST:               acc_rst_n_d = 1'b0;
      S_RUN, S_SCAN, S_REPORT: acc_en_d    = 1'b1;
      S_DONE:                  done_d      = 1'b1;
      default: ;
    endcase
  end

  // Outside RUN the edge register is held high, so a ready3 already high on RUN entry
  // cannot be mistaken for a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 4'd0;
      tmo_cnt  <= '0;
      r3_prev  <= 1'b1;
      tmo_flag <= 1'b0;
      idx      <= 4'd0;
      num_q    <= 8'd0;
    end else begin
      hold_cnt <= (state == S_PRE_RST) ? hold_cnt + 4'd1 : 4'd0;
      tmo_cnt  <= (state == S_RUN) ? tmo_cnt + TMO_W'(1) : '0;
      r3_prev  <= (state == S_RUN) ? ready3 : 1'b1;
      if (state == S_RUN) tmo_flag <= !r3_rise && tmo_hit;
      if (r3_rise)
        idx <= 4'd1;
      else if (state == S_SCAN)
        idx <= idx + 4'd1;
      if (state == S_IDLE && start_ok) num_q <= num_frames;
    end
  end

  // Stage p0: score capture at the ready3 edge; stage p1: running argmax.
  always_ff @(posedge clk) begin
    if (r3_rise) begin
      scores_p0   <= scores;
      best_p1     <= score_at(scores, 4'd0);
      best_idx_p1 <= 4'd0;
    end else if (state == S_SCAN) begin
      if (score_at(scores_p0, idx) > best_p1) begin
        best_p1     <= score_at(scores_p0, idx);
        best_idx_p1 <= idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_id    <= 4'd0;
      max_score   <= '0;
      class_valid <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      class_valid <= (state == S_REPORT);
      timeout_err <= (state == S_REPORT) && tmo_flag;
      if (state == S_IDLE && start_ok) frame_cnt <= 8'd0;
      if (state == S_REPORT) begin
        frame_cnt <= sat_inc8(frame_cnt);
        if (tmo_flag) begin
          class_id  <= 4'hF;
          max_score <= '0;
        end else begin
          class_id  <= best_idx_p1;
          max_score <= best_p1;
        end
      end
    end
  end

endmodule
